apx_adder_driver: RTL and testbench
===================================

APX_ADDER_DRIVER -- requirements
Module: apx_adder_driver

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, which sets the maximum number of cycles spent in SEND or WAIT_Z before the block aborts.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active-low.
- pair_a, pair_b  in  32  upstream IEEE-754 single-precision operand pair.
- pair_stb  in  1  upstream pair valid.
- pair_ack  out  1  upstream pair accepted.
- input_a, input_b  out  32  operands driven to the adder.
- input_a_stb, input_b_stb  out  1  operand valid, per port.
- input_a_ack, input_b_ack  in  1  adder accepted operand, per port.
- output_z  in  32  adder result.
- output_z_stb  in  1  adder result valid.
- output_z_ack  out  1  result consumed.
- res_z  out  32  captured result, sent downstream.
- res_stb  out  1  downstream result valid.
- res_ack  in  1  downstream accepted.
- pair_cnt  out  16  completed transactions; wraps 0xFFFF to 0x0000.
- timeout_err  out  1  sticky abort flag.

Function
REQ-003 A transfer SHALL occur on a rising edge where stb and its ack are both 1; this rule applies to every stb/ack pair on the block.
REQ-004 States SHALL be IDLE, SEND, WAIT_Z, ACK_Z and DELIVER; all outputs SHALL be registered.
REQ-005 IDLE: pair_ack = 1; on a pair transfer, latch pair_a into input_a and pair_b into input_b; next state SEND with input_a_stb = input_b_stb = 1.
REQ-006 SEND: each of input_a_stb and input_b_stb SHALL clear independently on the edge where its own ack is sampled high.
- Simultaneous acks clear both stbs on the same edge.
- WAIT_Z SHALL be entered on the edge where the last stb clears.
REQ-007 input_a and input_b SHALL hold stable while their respective stb is 1.
REQ-008 WAIT_Z: on the edge where output_z_stb = 1:
- capture output_z into res_z;
- go to ACK_Z with output_z_ack = 1.
REQ-009 ACK_Z SHALL last exactly one cycle; output_z_ack SHALL return to 0 on exit; next state DELIVER with res_stb = 1.
REQ-010 DELIVER: hold res_z and res_stb = 1 until res_ack is sampled high; on that edge:
- res_stb -> 0;
- pair_cnt increments;
- next state IDLE.
REQ-011 Minimum latency, pair transfer to res_stb = 1, SHALL be 4 cycles: the edge after the pair transfer with immediate acks enters SEND, then WAIT_Z, then ACK_Z (output_z_stb already high), then DELIVER.
REQ-012 Timeout counter:
- cleared on entry to SEND and on entry to WAIT_Z;
- increments each cycle spent in SEND or WAIT_Z;
- on reaching TIMEOUT_CYCLES, clear all stbs and output_z_ack, set timeout_err, go to IDLE;
- pair_cnt unchanged.
REQ-013 timeout_err SHALL clear only on reset.
REQ-014 output_z_stb asserted outside WAIT_Z SHALL be ignored.
REQ-015 pair_stb outside IDLE SHALL be ignored, since pair_ack = 0 there.

Reset
REQ-016 While rst = 0, all of the following SHALL be 0 and the state SHALL be IDLE: input_a, input_b, res_z, every stb output, output_z_ack, pair_cnt, timeout_err and the timeout counter.
REQ-017 pair_ack SHALL be 0 during reset and SHALL be 1 from the first edge after rst deasserts.
REQ-018 A reset in any state SHALL abandon the transaction without issuing output_z_ack.

Structure
REQ-019 The state encoding and the 16-bit count width SHALL be defined in shared package apx_float_pkg, alongside the float field widths (sign 1, exponent 8, mantissa 23).
REQ-020 The timeout counter SHALL be the sub-module hs_timeout; all other logic, including the FSM, SHALL stay in apx_adder_driver.

Verification
REQ-021 The bench SHALL cover these directed scenarios, against a behavioural adder responder:
- Basic, immediate responder: pair 3F99999A/40866666; responder returns 40ACCCCD -> res_z = 40ACCCCD; res_stb 4 cycles after pair transfer; output_z_ack high exactly 1 cycle; pair_cnt = 1.
- Skewed acks: input_a_ack after 2 cycles, input_b_ack after 5 -> input_a_stb drops first, input_b_stb drops 3 cycles later; WAIT_Z entered only after both; operands stable throughout.
- Downstream backpressure: res_ack held low 10 cycles -> res_stb and res_z stable for 10 cycles; pair_ack = 0 throughout; exactly one pair_cnt increment.
- Timeout: TIMEOUT_CYCLES = 8, output_z_stb never asserted -> IDLE after 8 cycles in WAIT_Z; timeout_err = 1 and sticky; next pair completes normally.
- Reset mid-operation: rst low during WAIT_Z -> all outputs 0 immediately (asynchronous); output_z_ack never pulses; pair_ack = 1 one edge after release.
- Counter wrap: preload pair_cnt = FFFF via 65535 transactions or force -> next completion gives 0000.

Source files
------------

// File: rtl/apx_float_pkg.sv
// Shared definitions for the adder driver: float field widths, count width
// and the driver state encoding.
package apx_float_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FLOAT_W = SIGN_W + EXP_W + MANT_W;
    localparam int CNT_W   = 16;

    typedef logic [FLOAT_W-1:0] float_word_t;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exponent;
        logic [MANT_W-1:0] mantissa;
    } float_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_Z  = 3'd2,
        ST_ACK_Z   = 3'd3,
        ST_DELIVER = 3'd4
    } drv_state_t;

    // View a raw 32-bit word as its IEEE-754 single-precision fields.
    function automatic float_t to_float(input float_word_t w);
        return float_t'(w);
    endfunction

endpackage

// File: rtl/apx_adder_driver_if.sv
// Handshake bundle between the upstream pair source, the adder and the
// downstream result sink. master = the driver, slave = its environment.
interface apx_adder_driver_if;
    import apx_float_pkg::*;

    float_word_t      pair_a;
    float_word_t      pair_b;
    logic             pair_stb;
    logic             pair_ack;

    float_word_t      input_a;
    float_word_t      input_b;
    logic             input_a_stb;
    logic             input_b_stb;
    logic             input_a_ack;
    logic             input_b_ack;

    float_word_t      output_z;
    logic             output_z_stb;
    logic             output_z_ack;

    float_word_t      res_z;
    logic             res_stb;
    logic             res_ack;

    logic [CNT_W-1:0] pair_cnt;
    logic             timeout_err;

    modport master (
        input  pair_a, pair_b, pair_stb,
        input  input_a_ack, input_b_ack,
        input  output_z, output_z_stb,
        input  res_ack,
        output pair_ack,
        output input_a, input_b, input_a_stb, input_b_stb,
        output output_z_ack,
        output res_z, res_stb,
        output pair_cnt, timeout_err
    );

    modport slave (
        output pair_a, pair_b, pair_stb,
        output input_a_ack, input_b_ack,
        output output_z, output_z_stb,
        output res_ack,
        input  pair_ack,
        input  input_a, input_b, input_a_stb, input_b_stb,
        input  output_z_ack,
        input  res_z, res_stb,
        input  pair_cnt, timeout_err
    );

endinterface

// File: rtl/hs_timeout.sv
// Cycle counter bounding how long the driver may wait on the adder.
// expired_o is high during the last permitted waiting cycle, so the abort
// edge lands exactly TIMEOUT_CYCLES cycles after the counter was cleared.
module hs_timeout #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over counting; hold when not waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == LAST);

endmodule

// File: rtl/apx_adder_driver.sv
// Feeds operand pairs into a stb/ack floating-point adder, collects the sum
// and hands it downstream. Aborts with a sticky flag if the adder stalls.
module apx_adder_driver
    import apx_float_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    apx_adder_driver_if.master   bus
);

    drv_state_t       state_q;
    float_word_t      input_a_q;
    float_word_t      input_b_q;
    float_word_t      res_z_q;
    logic             input_a_stb_q;
    logic             input_b_stb_q;
    logic             output_z_ack_q;
    logic             res_stb_q;
    logic             pair_ack_q;
    logic             timeout_err_q;
    logic [CNT_W-1:0] pair_cnt_q;

    logic pair_xfer;
    logic a_xfer;
    logic b_xfer;
    logic send_done;
    logic tmo_run;
    logic tmo_clr;
    logic tmo_expired;

    assign pair_xfer = (state_q == ST_IDLE) && pair_ack_q && bus.pair_stb;
    assign a_xfer    = input_a_stb_q && bus.input_a_ack;
    assign b_xfer    = input_b_stb_q && bus.input_b_ack;
    // SEND is finished once every operand still outstanding is taken this edge.
    assign send_done = (state_q == ST_SEND)
                     && (!input_a_stb_q || bus.input_a_ack)
                     && (!input_b_stb_q || bus.input_b_ack);

    // Counter runs only while waiting on the adder; it is held at zero
    // elsewhere and re-cleared on the SEND -> WAIT_Z transition.
    assign tmo_run = (state_q == ST_SEND) || (state_q == ST_WAIT_Z);
    assign tmo_clr = send_done || !tmo_run;

    hs_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst),
        .run_i     (tmo_run),
        .clr_i     (tmo_clr),
        .expired_o (tmo_expired)
    );

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            input_a_q      <= '0;
            input_b_q      <= '0;
            res_z_q        <= '0;
            input_a_stb_q  <= 1'b0;
            input_b_stb_q  <= 1'b0;
            output_z_ack_q <= 1'b0;
            res_stb_q      <= 1'b0;
            pair_ack_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            pair_cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pair_ack_q <= !pair_xfer;
                    if (pair_xfer) begin
                        input_a_q     <= bus.pair_a;
                        input_b_q     <= bus.pair_b;
                        input_a_stb_q <= 1'b1;
                        input_b_stb_q <= 1'b1;
                        state_q       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (a_xfer) input_a_stb_q <= 1'b0;
                    if (b_xfer) input_b_stb_q <= 1'b0;
                    // Progress on the final edge takes priority over abort.
                    if (send_done) begin
                        state_q <= ST_WAIT_Z;
                    end else if (tmo_expired) begin
                        input_a_stb_q  <= 1'b0;
                        input_b_stb_q  <= 1'b0;
                        output_z_ack_q <= 1'b0;
                        timeout_err_q  <= 1'b1;
                        pair_ack_q     <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                ST_WAIT_Z: begin
                    if (bus.output_z_stb) begin
                        res_z_q        <= bus.output_z;
                        output_z_ack_q <= 1'b1;
                        state_q        <= ST_ACK_Z;
                    end else if (tmo_expired) begin
                        input_a_stb_q  <= 1'b0;
                        input_b_stb_q  <= 1'b0;
                        output_z_ack_q <= 1'b0;
                        timeout_err_q  <= 1'b1;
                        pair_ack_q     <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
                ST_ACK_Z: begin
                    output_z_ack_q <= 1'b0;
                    res_stb_q      <= 1'b1;
                    state_q        <= ST_DELIVER;
                end
                ST_DELIVER: begin
                    if (bus.res_ack) begin
                        res_stb_q  <= 1'b0;
                        pair_cnt_q <= pair_cnt_q + CNT_W'(1);
                        pair_ack_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    input_a_stb_q  <= 1'b0;
                    input_b_stb_q  <= 1'b0;
                    output_z_ack_q <= 1'b0;
                    res_stb_q      <= 1'b0;
                    pair_ack_q     <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pair_ack     = pair_ack_q;
    assign bus.input_a      = input_a_q;
    assign bus.input_b      = input_b_q;
    assign bus.input_a_stb  = input_a_stb_q;
    assign bus.input_b_stb  = input_b_stb_q;
    assign bus.output_z_ack = output_z_ack_q;
    assign bus.res_z        = res_z_q;
    assign bus.res_stb      = res_stb_q;
    assign bus.pair_cnt     = pair_cnt_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_apx_adder_driver.sv
// Bench for apx_adder_driver: a behavioural adder responder plus directed
// and randomized transaction scenarios checked against expected timing/data.
module tb_apx_adder_driver;

    localparam int TMO = 8;

    logic clk;
    logic rst;

    apx_adder_driver_if bus ();

    apx_adder_driver #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors;
    int          checks;
    int          cyc;
    int          zack_cycles;
    logic [15:0] model_cnt;

    // Responder configuration (written by tests) and observations.
    int          a_dly;
    int          b_dly;
    int          z_dly;
    bit          z_en;
    logic [31:0] rsp_z;
    logic [31:0] seen_a;
    logic [31:0] seen_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        zack_cycles = 0;
        forever begin
            @(negedge clk);
            if (bus.output_z_ack === 1'b1) zack_cycles++;
        end
    end

    // Behavioural adder: acks each operand after its configured delay, then
    // presents rsp_z after z_dly cycles and holds it until the sum transfers.
    initial begin : adder_responder
        int a_cnt;
        int b_cnt;
        int z_cnt;
        bit a_done;
        bit b_done;
        bit z_done;
        bit z_ack_prev;
        a_cnt = 0; b_cnt = 0; z_cnt = 0;
        a_done = 0; b_done = 0; z_done = 0; z_ack_prev = 0;
        bus.input_a_ack  = 1'b0;
        bus.input_b_ack  = 1'b0;
        bus.output_z_stb = 1'b0;
        bus.output_z     = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 || bus.pair_ack === 1'b1) begin
                a_cnt = 0; b_cnt = 0; z_cnt = 0;
                a_done = 0; b_done = 0; z_done = 0; z_ack_prev = 0;
                bus.input_a_ack  = 1'b0;
                bus.input_b_ack  = 1'b0;
                bus.output_z_stb = 1'b0;
            end else begin
                if (bus.input_a_ack && !bus.input_a_stb) a_done = 1;
                if (bus.input_b_ack && !bus.input_b_stb) b_done = 1;
                if (bus.input_a_stb) begin
                    if (a_cnt >= a_dly) begin
                        bus.input_a_ack = 1'b1;
                        seen_a = bus.input_a;
                    end else begin
                        bus.input_a_ack = 1'b0;
                        a_cnt++;
                    end
                end else begin
                    bus.input_a_ack = 1'b0;
                end
                if (bus.input_b_stb) begin
                    if (b_cnt >= b_dly) begin
                        bus.input_b_ack = 1'b1;
                        seen_b = bus.input_b;
                    end else begin
                        bus.input_b_ack = 1'b0;
                        b_cnt++;
                    end
                end else begin
                    bus.input_b_ack = 1'b0;
                end
                if (z_ack_prev && bus.output_z_stb) begin
                    bus.output_z_stb = 1'b0;
                    z_done = 1;
                end else if (a_done && b_done && z_en && !z_done && !bus.output_z_stb) begin
                    if (z_cnt >= z_dly) begin
                        bus.output_z_stb = 1'b1;
                        bus.output_z     = rsp_z;
                    end else begin
                        z_cnt++;
                    end
                end
                z_ack_prev = bus.output_z_ack;
            end
        end
    end

    // Offer a pair until accepted; xfer_cyc is the edge index of the transfer.
    task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                             output int xfer_cyc, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        bus.pair_a   = a;
        bus.pair_b   = b;
        bus.pair_stb = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.pair_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        xfer_cyc     = cyc;
        bus.pair_stb = 1'b0;
        bus.pair_a   = $urandom();
        bus.pair_b   = $urandom();
    endtask

    task automatic wait_res(output int res_cyc, output bit ok);
        ok = 1'b0;
        res_cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.res_stb === 1'b1) begin
                ok = 1'b1;
                res_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic give_res_ack(input int dly);
        @(negedge clk);
        repeat (dly) @(negedge clk);
        bus.res_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.pair_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_pair_ack: got %b want 0", bus.pair_ack);
        end
        checks++;
        if ({bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, bus.res_stb, bus.timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, bus.res_stb, bus.timeout_err});
        end
        checks++;
        if ({bus.input_a, bus.input_b, bus.res_z} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0", bus.input_a, bus.input_b, bus.res_z);
        end
        checks++;
        if (bus.pair_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cnt: got %h want 0000", bus.pair_cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pair_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_pair_ack: got %b want 1", bus.pair_ack);
        end
        model_cnt = 16'h0000;
        $display("txn reset: released");
    endtask

    task automatic test_basic();
        int  t_x, t_r, z0;
        bit  ok1, ok2;
        a_dly = 0; b_dly = 0; z_dly = 0; z_en = 1;
        rsp_z = 32'h40ACCCCD;
        z0 = zack_cycles;
        send_pair(32'h3F99999A, 32'h40866666, t_x, ok1);
        wait_res(t_r, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL basic_progress: pair_ok=%0b res_ok=%0b want 1 1", ok1, ok2);
        end
        // Latency counted with the transfer edge as the first cycle.
        checks++;
        if (t_r - t_x + 1 != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 4", t_r - t_x + 1);
        end
        checks++;
        if (bus.res_z !== 32'h40ACCCCD) begin
            errors++;
            $display("FAIL basic_res_z: got %h want 40accccd", bus.res_z);
        end
        checks++;
        if (seen_a !== 32'h3F99999A || seen_b !== 32'h40866666) begin
            errors++;
            $display("FAIL basic_operands: got %h %h want 3f99999a 40866666", seen_a, seen_b);
        end
        give_res_ack(0);
        model_cnt = model_cnt + 16'd1;
        checks++;
        if (zack_cycles - z0 != 1) begin
            errors++;
            $display("FAIL basic_zack_width: got %0d want 1", zack_cycles - z0);
        end
        checks++;
        if (bus.pair_cnt !== model_cnt) begin
            errors++;
            $display("FAIL basic_cnt: got %h want %h", bus.pair_cnt, model_cnt);
        end
        checks++;
        if (bus.res_stb !== 1'b0 || bus.pair_ack !== 1'b1) begin
            errors++;
            $display("FAIL basic_return_idle: res_stb=%b pair_ack=%b want 0 1", bus.res_stb, bus.pair_ack);
        end
        $display("txn basic: z=%h cnt=%h", bus.res_z, bus.pair_cnt);
    endtask

    task automatic test_skew();
        int          t_x, t_r, a_fall, b_fall, zack_edge;
        bit          ok1, ok2, unstable;
        logic [31:0] pa, pb;
        pa = $urandom(); pb = $urandom();
        a_dly = 2; b_dly = 5; z_dly = 0; z_en = 1;
        rsp_z = $urandom();
        a_fall = -1; b_fall = -1; zack_edge = -1; unstable = 0;
        send_pair(pa, pb, t_x, ok1);
        ok2 = 0; t_r = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.input_a_stb === 1'b1 && bus.input_a !== pa) unstable = 1;
            if (bus.input_b_stb === 1'b1 && bus.input_b !== pb) unstable = 1;
            if (a_fall < 0 && bus.input_a_stb === 1'b0) a_fall = cyc;
            if (b_fall < 0 && bus.input_b_stb === 1'b0) b_fall = cyc;
            if (zack_edge < 0 && bus.output_z_ack === 1'b1) zack_edge = cyc;
            if (bus.res_stb === 1'b1) begin
                ok2 = 1; t_r = cyc;
                break;
            end
        end
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL skew_progress: pair_ok=%0b res_ok=%0b want 1 1", ok1, ok2);
        end
        checks++;
        if (a_fall - t_x != 3) begin
            errors++;
            $display("FAIL skew_a_drop: got %0d want 3 cycles after transfer", a_fall - t_x);
        end
        checks++;
        if (b_fall - a_fall != 3) begin
            errors++;
            $display("FAIL skew_b_after_a: got %0d want 3", b_fall - a_fall);
        end
        checks++;
        if (zack_edge - b_fall != 1) begin
            errors++;
            $display("FAIL skew_wait_after_both: got %0d want 1", zack_edge - b_fall);
        end
        checks++;
        if (unstable || seen_a !== pa || seen_b !== pb) begin
            errors++;
            $display("FAIL skew_operands: unstable=%0b seen %h %h want %h %h", unstable, seen_a, seen_b, pa, pb);
        end
        checks++;
        if (bus.res_z !== rsp_z) begin
            errors++;
            $display("FAIL skew_res_z: got %h want %h", bus.res_z, rsp_z);
        end
        give_res_ack(0);
        model_cnt = model_cnt + 16'd1;
        checks++;
        if (bus.pair_cnt !== model_cnt) begin
            errors++;
            $display("FAIL skew_cnt: got %h want %h", bus.pair_cnt, model_cnt);
        end
        $display("txn skew: a=%h b=%h z=%h", pa, pb, bus.res_z);
    endtask

    task automatic test_backpressure();
        int t_x, t_r, bad;
        bit ok1, ok2;
        a_dly = 0; b_dly = 0; z_dly = 1; z_en = 1;
        rsp_z = $urandom();
        bad = 0;
        send_pair($urandom(), $urandom(), t_x, ok1);
        wait_res(t_r, ok2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res_stb !== 1'b1 || bus.res_z !== rsp_z || bus.pair_ack !== 1'b0) bad++;
        end
        bus.res_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ack = 1'b0;
        model_cnt = model_cnt + 16'd1;
        checks++;
        if (!(ok1 && ok2) || bad != 0) begin
            errors++;
            $display("FAIL bp_hold: bad_cycles=%0d progress=%0b%0b want 0 11", bad, ok1, ok2);
        end
        checks++;
        if (bus.res_stb !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: res_stb got %b want 0", bus.res_stb);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.pair_cnt !== model_cnt) begin
            errors++;
            $display("FAIL bp_cnt: got %h want %h", bus.pair_cnt, model_cnt);
        end
        $display("txn backpressure: z=%h cnt=%h", rsp_z, bus.pair_cnt);
    endtask

    task automatic test_random();
        int          t_x, t_r, exp_lat;
        bit          ok1, ok2;
        logic [31:0] pa, pb;
        for (int n = 0; n < 20; n++) begin
            pa = $urandom(); pb = $urandom();
            a_dly = $urandom_range(0, 5);
            b_dly = $urandom_range(0, 5);
            z_dly = $urandom_range(0, 4);
            z_en  = 1;
            rsp_z = $urandom();
            exp_lat = 4 + ((a_dly > b_dly) ? a_dly : b_dly) + z_dly;
            send_pair(pa, pb, t_x, ok1);
            wait_res(t_r, ok2);
            checks++;
            if (!(ok1 && ok2) || t_r - t_x + 1 != exp_lat) begin
                errors++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", n, t_r - t_x + 1, exp_lat);
            end
            checks++;
            if (bus.res_z !== rsp_z) begin
                errors++;
                $display("FAIL rand_res_z[%0d]: got %h want %h", n, bus.res_z, rsp_z);
            end
            checks++;
            if (seen_a !== pa || seen_b !== pb) begin
                errors++;
                $display("FAIL rand_operands[%0d]: got %h %h want %h %h", n, seen_a, seen_b, pa, pb);
            end
            give_res_ack($urandom_range(0, 3));
            model_cnt = model_cnt + 16'd1;
            checks++;
            if (bus.pair_cnt !== model_cnt) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %h want %h", n, bus.pair_cnt, model_cnt);
            end
            $display("txn rand %0d: a=%h b=%h z=%h lat=%0d", n, pa, pb, rsp_z, t_r - t_x + 1);
        end
    endtask

    task automatic test_timeout();
        int t_x, t_r, b_fall, idle_edge, z0;
        bit ok1, ok2;
        a_dly = 0; b_dly = 0; z_dly = 0; z_en = 0;
        z0 = zack_cycles;
        b_fall = -1; idle_edge = -1;
        send_pair($urandom(), $urandom(), t_x, ok1);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (b_fall < 0 && bus.input_b_stb === 1'b0 && bus.input_a_stb === 1'b0) b_fall = cyc;
            if (bus.pair_ack === 1'b1) begin
                idle_edge = cyc;
                break;
            end
        end
        checks++;
        if (!ok1 || idle_edge - b_fall != TMO) begin
            errors++;
            $display("FAIL tmo_wait_len: got %0d want %0d", idle_edge - b_fall, TMO);
        end
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.res_stb !== 1'b0 || zack_cycles != z0) begin
            errors++;
            $display("FAIL tmo_abort: err=%b res_stb=%b zack=%0d want 1 0 0",
                     bus.timeout_err, bus.res_stb, zack_cycles - z0);
        end
        checks++;
        if (bus.pair_cnt !== model_cnt) begin
            errors++;
            $display("FAIL tmo_cnt: got %h want %h", bus.pair_cnt, model_cnt);
        end
        // The next pair completes normally while the flag stays set.
        z_en = 1;
        rsp_z = $urandom();
        send_pair($urandom(), $urandom(), t_x, ok1);
        wait_res(t_r, ok2);
        checks++;
        if (!(ok1 && ok2) || bus.res_z !== rsp_z) begin
            errors++;
            $display("FAIL tmo_recover_z: got %h want %h", bus.res_z, rsp_z);
        end
        give_res_ack(0);
        model_cnt = model_cnt + 16'd1;
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.pair_cnt !== model_cnt) begin
            errors++;
            $display("FAIL tmo_sticky: err=%b cnt=%h want 1 %h", bus.timeout_err, bus.pair_cnt, model_cnt);
        end
        $display("txn timeout: err=%b cnt=%h", bus.timeout_err, bus.pair_cnt);
    endtask

    task automatic test_reset_mid();
        int t_x, z0;
        bit ok1;
        a_dly = 0; b_dly = 0; z_dly = 0; z_en = 0;
        z0 = zack_cycles;
        send_pair($urandom(), $urandom(), t_x, ok1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, bus.res_stb,
             bus.timeout_err, bus.pair_ack} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_flags: got %b want 000000",
                     {bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, bus.res_stb, bus.timeout_err, bus.pair_ack});
        end
        checks++;
        if ({bus.input_a, bus.input_b, bus.res_z} !== 96'b0 || bus.pair_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_data: got %h %h %h cnt=%h want 0", bus.input_a, bus.input_b, bus.res_z, bus.pair_cnt);
        end
        model_cnt = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pair_ack !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pair_ack: got %b want 1", bus.pair_ack);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (zack_cycles != z0 || !ok1) begin
            errors++;
            $display("FAIL midrst_no_zack: got %0d pulses want 0", zack_cycles - z0);
        end
        $display("txn reset_mid: cnt=%h", bus.pair_cnt);
    endtask

    task automatic test_wrap();
        int t_x, t_r;
        bit ok1, ok2;
        @(negedge clk);
        force dut.pair_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.pair_cnt_q;
        model_cnt = 16'hFFFF;
        a_dly = 0; b_dly = 0; z_dly = 0; z_en = 1;
        rsp_z = $urandom();
        send_pair($urandom(), $urandom(), t_x, ok1);
        wait_res(t_r, ok2);
        give_res_ack(1);
        model_cnt = model_cnt + 16'd1;
        checks++;
        if (!(ok1 && ok2) || bus.pair_cnt !== model_cnt) begin
            errors++;
            $display("FAIL wrap_cnt: got %h want %h", bus.pair_cnt, model_cnt);
        end
        $display("txn wrap: cnt=%h", bus.pair_cnt);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        model_cnt = 16'h0000;
        rst = 1'b0;
        bus.pair_a = '0;
        bus.pair_b = '0;
        bus.pair_stb = 1'b0;
        bus.res_ack = 1'b0;
        a_dly = 0; b_dly = 0; z_dly = 0; z_en = 1;
        rsp_z = '0; seen_a = '0; seen_b = '0;
        test_reset();
        test_basic();
        test_skew();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
